// File: rtl/mcyc_ctrl_if.sv
// mcyc_ctrl_if: control bundle between the multicycle sequencer and the
// datapath/memory it drives.
//   iOp, iFunct    : instruction fields from IR
//   iZero          : ALU zero flag
//   iMemReady      : memory completes the current access this cycle
//   oMemReq..oIllegal : datapath/memory control strobes and selects
//   oInstCount     : retired-instruction count (CNT_W bits)
//   oState         : current sequencer state, for debug
// master = sequencer side, slave = datapath side.
interface mcyc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       iOp;
  logic [5:0]       iFunct;
  logic             iZero;
  logic             iMemReady;
  logic             oMemReq;
  logic             oIorD;
  logic             oMemWrite;
  logic             oIRWrite;
  logic             oPCEn;
  logic [1:0]       oPCSrc;
  logic             oALUSrcA;
  logic [1:0]       oALUSrcB;
  logic [2:0]       oALUControl;
  logic             oRegDst;
  logic             oMemtoReg;
  logic             oRegWrite;
  logic             oRetire;
  logic             oIllegal;
  logic [CNT_W-1:0] oInstCount;
  logic [3:0]       oState;

  modport master (
    input  iOp, iFunct, iZero, iMemReady,
    output oMemReq, oIorD, oMemWrite, oIRWrite, oPCEn, oPCSrc, oALUSrcA,
           oALUSrcB, oALUControl, oRegDst, oMemtoReg, oRegWrite, oRetire,
           oIllegal, oInstCount, oState
  );

  modport slave (
    output iOp, iFunct, iZero, iMemReady,
    input  oMemReq, oIorD, oMemWrite, oIRWrite, oPCEn, oPCSrc, oALUSrcA,
           oALUSrcB, oALUControl, oRegDst, oMemtoReg, oRegWrite, oRetire,
           oIllegal, oInstCount, oState
  );
endinterface

// File: rtl/mcyc_ctrl.sv
// mcyc_ctrl: multicycle MIPS control sequencer for a shared ALU, register
// file and unified instruction/data memory, with a memory ready handshake and
// a retired-instruction counter.
// Ports:
//   iClk      : clock, all state changes on the rising edge
//   iReset_n  : synchronous active-low reset; forces every output to 0 while low
//   bus       : mcyc_ctrl_if.master control bundle (see mcyc_ctrl_if.sv)
//
// state    | code | meaning
// FETCH    | 0    | read instruction at PC, PC+4; waits on ready
// DECODE   | 1    | branch target into ALUOut, dispatch on opcode
// MEMADR   | 2    | A + SignImm address for lw/sw
// MEMREAD  | 3    | data read at ALUOut; waits on ready
// MEMWB    | 4    | MDR -> rt
// MEMWRITE | 5    | store B at ALUOut; waits on ready
// EXECUTE  | 6    | R-type ALU op
// ALUWB    | 7    | ALUOut -> rd
// BRANCH   | 8    | beq compare, PC <- ALUOut when zero
// ADDIEX   | 9    | A + SignImm
// ADDIWB   | 10   | ALUOut -> rt
// JUMP     | 11   | PC <- jump target
module mcyc_ctrl #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic       iClk,
  input  logic       iReset_n,
  mcyc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic       w_ready;
  logic       w_legal;
  logic       w_memreq, w_iord, w_memwrite, w_irwrite, w_pcen;
  logic [1:0] w_pcsrc;
  logic       w_srca;
  logic [1:0] w_srcb;
  logic [2:0] w_alu;
  logic       w_regdst, w_memtoreg, w_regwrite, w_retire, w_illegal;
  logic [2:0] w_funct_alu;

  assign w_ready = USE_MEM_READY ? bus.iMemReady : 1'b1;

  assign w_legal = (bus.iOp == OP_LW)   || (bus.iOp == OP_SW)  ||
                   (bus.iOp == OP_RTYP) || (bus.iOp == OP_BEQ) ||
                   (bus.iOp == OP_ADDI) || (bus.iOp == OP_J);

  // Unknown funct codes fall back to add without flagging illegal.
  always_comb begin
    w_funct_alu = ALU_ADD;
    case (bus.iFunct)
      6'b100000: w_funct_alu = ALU_ADD;
      6'b100010: w_funct_alu = ALU_SUB;
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b101010: w_funct_alu = ALU_SLT;
      default:   w_funct_alu = ALU_ADD;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      if (w_retire) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      case (r_state)
        S_FETCH:    if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.iOp)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYP:      r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        // IR holds iOp stable, so it still distinguishes lw from sw here.
        S_MEMADR:   r_state <= (bus.iOp == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (w_ready) r_state <= S_FETCH;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_ADDIEX:   r_state <= S_ADDIWB;
        S_ADDIWB:   r_state <= S_FETCH;
        S_JUMP:     r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; only the handshake strobes look at ready/zero/opcode.
  always_comb begin
    w_memreq   = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcen     = 1'b0;
    w_pcsrc    = 2'b00;
    w_srca     = 1'b0;
    w_srcb     = 2'b00;
    w_alu      = 3'b000;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memreq  = 1'b1;
        w_srcb    = 2'b01;
        w_alu     = ALU_ADD;
        w_irwrite = w_ready;
        w_pcen    = w_ready;
      end
      S_DECODE: begin
        w_srcb = 2'b11;
        w_alu  = ALU_ADD;
        if (!w_legal) begin
          w_illegal = 1'b1;
          w_retire  = 1'b1;
        end
      end
      S_MEMADR: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_alu  = ALU_ADD;
      end
      S_MEMREAD: begin
        w_memreq = 1'b1;
        w_iord   = 1'b1;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWRITE: begin
        w_memreq   = 1'b1;
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = w_ready;
      end
      S_EXECUTE: begin
        w_srca = 1'b1;
        w_alu  = w_funct_alu;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        w_srca   = 1'b1;
        w_alu    = ALU_SUB;
        w_pcsrc  = 2'b01;
        w_pcen   = bus.iZero;
        w_retire = 1'b1;
      end
      S_ADDIEX: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_alu  = ALU_ADD;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc  = 2'b10;
        w_pcen   = 1'b1;
        w_retire = 1'b1;
      end
      default: ;
    endcase
  end

  // Everything is held at 0 while reset is asserted, so an abandoned
  // instruction cannot leave a write strobe active.
  assign bus.oMemReq     = iReset_n & w_memreq;
  assign bus.oIorD       = iReset_n & w_iord;
  assign bus.oMemWrite   = iReset_n & w_memwrite;
  assign bus.oIRWrite    = iReset_n & w_irwrite;
  assign bus.oPCEn       = iReset_n & w_pcen;
  assign bus.oPCSrc      = {2{iReset_n}} & w_pcsrc;
  assign bus.oALUSrcA    = iReset_n & w_srca;
  assign bus.oALUSrcB    = {2{iReset_n}} & w_srcb;
  assign bus.oALUControl = {3{iReset_n}} & w_alu;
  assign bus.oRegDst     = iReset_n & w_regdst;
  assign bus.oMemtoReg   = iReset_n & w_memtoreg;
  assign bus.oRegWrite   = iReset_n & w_regwrite;
  assign bus.oRetire     = iReset_n & w_retire;
  assign bus.oIllegal    = iReset_n & w_illegal;
  assign bus.oInstCount  = iReset_n ? r_cnt : '0;
  assign bus.oState      = iReset_n ? r_state : 4'd0;

endmodule

// File: tb/tb_mcyc_ctrl.sv
module tb_mcyc_ctrl;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic iClk = 1'b0;
  logic iReset_n = 1'b0;
  always #5 iClk = ~iClk;

  mcyc_ctrl_if #(.CNT_W(32)) bus  ();
  mcyc_ctrl_if #(.CNT_W(4))  bus4 ();
  mcyc_ctrl_if #(.CNT_W(32)) bus0 ();

  mcyc_ctrl #(.USE_MEM_READY(1'b1), .CNT_W(32)) dut  (.iClk(iClk), .iReset_n(iReset_n), .bus(bus));
  mcyc_ctrl #(.USE_MEM_READY(1'b1), .CNT_W(4))  dut4 (.iClk(iClk), .iReset_n(iReset_n), .bus(bus4));
  mcyc_ctrl #(.USE_MEM_READY(1'b0), .CNT_W(32)) dut0 (.iClk(iClk), .iReset_n(iReset_n), .bus(bus0));

  assign bus4.iOp = bus.iOp;
  assign bus4.iFunct = bus.iFunct;
  assign bus4.iZero = bus.iZero;
  assign bus4.iMemReady = bus.iMemReady;
  assign bus0.iOp = bus.iOp;
  assign bus0.iFunct = bus.iFunct;
  assign bus0.iZero = bus.iZero;
  assign bus0.iMemReady = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_cycles = 0;
  int n_ret = 0;
  bit nowait = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [21:0] last_got[$];

  typedef struct {
    int st;
    bit rdy;
  } step_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, n_cycles, got, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ ||
           op == OP_ADDI || op == OP_J;
  endfunction

  // Expected output word from the state name table in the description:
  // {state, memreq, iord, memwrite, irwrite, pcen, pcsrc, srca, srcb, alu,
  //  regdst, memtoreg, regwrite, retire, illegal}
  function automatic logic [21:0] exp_outs(input int st, input bit rdy, input bit zero,
                                           input logic [5:0] op, input logic [5:0] funct);
    logic mreq = 0, iord = 0, mw = 0, irw = 0, pcen = 0, srca = 0;
    logic rdst = 0, m2r = 0, rw = 0, ret = 0, ill = 0;
    logic [1:0] pcsrc = 0, srcb = 0;
    logic [2:0] alu = 0;
    case (st)
      0: begin mreq = 1; srcb = 2'b01; alu = 3'b010; irw = rdy; pcen = rdy; end
      1: begin srcb = 2'b11; alu = 3'b010; ill = !is_legal(op); ret = ill; end
      2: begin srca = 1; srcb = 2'b10; alu = 3'b010; end
      3: begin mreq = 1; iord = 1; end
      4: begin m2r = 1; rw = 1; ret = 1; end
      5: begin mreq = 1; iord = 1; mw = 1; ret = rdy; end
      6: begin srca = 1; alu = alu_of(funct); end
      7: begin rdst = 1; rw = 1; ret = 1; end
      8: begin srca = 1; alu = 3'b110; pcsrc = 2'b01; pcen = zero; ret = 1; end
      9: begin srca = 1; srcb = 2'b10; alu = 3'b010; end
      10: begin rw = 1; ret = 1; end
      11: begin pcsrc = 2'b10; pcen = 1; ret = 1; end
      default: ;
    endcase
    return {4'(st), mreq, iord, mw, irw, pcen, pcsrc, srca, srcb, alu, rdst, m2r, rw, ret, ill};
  endfunction

  task automatic do_cycle(input int st, input bit rdy, input logic [5:0] op,
                          input logic [5:0] funct, input bit zero, input bit rst);
    logic [21:0] exp, got, got0;
    @(posedge iClk);
    #1;
    iReset_n = !rst;
    bus.iOp = (st == 0 || rst) ? 6'($urandom) : op;
    bus.iFunct = funct;
    bus.iZero = (st == 8) ? zero : 1'($urandom);
    bus.iMemReady = (st == 0 || st == 3 || st == 5) ? rdy : 1'($urandom);
    @(negedge iClk);
    n_cycles++;
    exp = rst ? 22'd0 : exp_outs(st, rdy, zero, op, funct);
    got = {bus.oState, bus.oMemReq, bus.oIorD, bus.oMemWrite, bus.oIRWrite, bus.oPCEn,
           bus.oPCSrc, bus.oALUSrcA, bus.oALUSrcB, bus.oALUControl, bus.oRegDst,
           bus.oMemtoReg, bus.oRegWrite, bus.oRetire, bus.oIllegal};
    last_got.push_back(got);
    n_ret += int'(got[1]);
    chk("outs", 64'(got), 64'(exp));
    chk("count", 64'(bus.oInstCount), rst ? 64'd0 : 64'(m_cnt));
    chk("count4", 64'(bus4.oInstCount), rst ? 64'd0 : 64'(m_cnt[3:0]));
    if (nowait) begin
      got0 = {bus0.oState, bus0.oMemReq, bus0.oIorD, bus0.oMemWrite, bus0.oIRWrite, bus0.oPCEn,
              bus0.oPCSrc, bus0.oALUSrcA, bus0.oALUSrcB, bus0.oALUControl, bus0.oRegDst,
              bus0.oMemtoReg, bus0.oRegWrite, bus0.oRetire, bus0.oIllegal};
      chk("outs_noready", 64'(got0), 64'(exp));
    end
    if (rst) m_cnt = '0;
    else if (exp[1]) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
  endtask

  // Builds the cycle-by-cycle state path of one instruction from its class,
  // fetch wait count fw and data-memory wait count mw, then plays it.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input bit zero,
                           input int fw, input int mw, input int abort_at);
    step_t q[$];
    last_got.delete();
    for (int i = 0; i < fw; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'b1});
    if (op == OP_LW || op == OP_SW) begin
      q.push_back('{2, 1'b1});
      for (int i = 0; i < mw; i++) q.push_back('{(op == OP_LW) ? 3 : 5, 1'b0});
      q.push_back('{(op == OP_LW) ? 3 : 5, 1'b1});
      if (op == OP_LW) q.push_back('{4, 1'b1});
    end else if (op == OP_R) begin
      q.push_back('{6, 1'b1});
      q.push_back('{7, 1'b1});
    end else if (op == OP_BEQ) begin
      q.push_back('{8, 1'b1});
    end else if (op == OP_ADDI) begin
      q.push_back('{9, 1'b1});
      q.push_back('{10, 1'b1});
    end else if (op == OP_J) begin
      q.push_back('{11, 1'b1});
    end
    foreach (q[i]) begin
      if (i == abort_at) begin
        do_reset(2);
        return;
      end
      do_cycle(q[i].st, q[i].rdy, op, funct, zero, 1'b0);
    end
  endtask

  localparam logic [21:0] V_FETCH_RDY  = {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [21:0] V_FETCH_WAIT = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [21:0] V_BR_NZ      = {4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [21:0] V_BR_Z       = {4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [21:0] V_ILLEGAL    = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [21:0] V_MW_WAIT    = {4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0;
    logic [5:0] ops[6];
    logic [5:0] functs[6];
    ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    bus.iOp = '0;
    bus.iFunct = '0;
    bus.iZero = 1'b0;
    bus.iMemReady = 1'b0;

    nowait = 1'b1;
    do_reset(2);

    c0 = n_cycles;
    r0 = n_ret;
    run_instr(OP_LW, 6'b100000, 1'b0, 0, 0, -1);
    chk("first_fetch", 64'(last_got[0]), 64'(V_FETCH_RDY));
    run_instr(OP_SW, 6'b100000, 1'b0, 0, 0, -1);
    run_instr(OP_R, 6'b100000, 1'b0, 0, 0, -1);
    run_instr(OP_ADDI, 6'b100000, 1'b0, 0, 0, -1);
    run_instr(OP_BEQ, 6'b100000, 1'b0, 0, 0, -1);
    chk("beq_nz", 64'(last_got[2]), 64'(V_BR_NZ));
    run_instr(OP_J, 6'b100000, 1'b0, 0, 0, -1);
    chk("six_cycles", 64'(n_cycles - c0), 64'd23);
    chk("six_retires", 64'(n_ret - r0), 64'd6);
    chk("six_count", 64'(m_cnt), 64'd6);

    run_instr(OP_BEQ, 6'b100000, 1'b1, 0, 0, -1);
    chk("beq_z", 64'(last_got[2]), 64'(V_BR_Z));
    run_instr(6'b111111, 6'b100000, 1'b0, 0, 0, -1);
    chk("illegal_decode", 64'(last_got[1]), 64'(V_ILLEGAL));
    chk("illegal_len", 64'(last_got.size()), 64'd2);

    do_reset(1);
    for (int i = 0; i < 17; i++) run_instr(OP_J, 6'd0, 1'b0, 0, 0, -1);
    chk("cnt17", 64'(m_cnt), 64'd17);
    run_instr(OP_R, 6'b100101, 1'b0, 0, 0, -1);
    chk("cnt4_wrap", 64'(bus4.oInstCount), 64'd1);
    nowait = 1'b0;

    run_instr(OP_J, 6'd0, 1'b0, 3, 0, -1);
    chk("fetch_wait0", 64'(last_got[0]), 64'(V_FETCH_WAIT));
    chk("fetch_wait2", 64'(last_got[2]), 64'(V_FETCH_WAIT));
    chk("fetch_fire", 64'(last_got[3]), 64'(V_FETCH_RDY));
    run_instr(OP_SW, 6'd0, 1'b0, 0, 3, -1);
    chk("mw_wait", 64'(last_got[4]), 64'(V_MW_WAIT));
    run_instr(OP_LW, 6'd0, 1'b0, 0, 3, -1);

    run_instr(OP_SW, 6'd0, 1'b0, 0, 3, 4);
    chk("rst_mw", 64'(last_got[4]), 64'd0);
    chk("rst_cnt", 64'(m_cnt), 64'd0);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      int fw, mw, ab;
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom);
        if (is_legal(op)) op = 6'b111110;
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
      fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      ab = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(op, fn, 1'($urandom), fw, mw, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
